// File: rtl/shift_in_scan.sv
// Reader for a 74HC165-style parallel-in/serial-out chain: pulses the load line,
// shifts WIDTH bits in MSB-first and publishes them with a one-cycle valid strobe.
module shift_in_scan #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned CLK_DIV = 4,
  parameter bit          AUTO    = 1'b0,
  parameter bit          INVERT  = 1'b0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  output logic             sr_load_n,
  output logic             sr_clk,
  input  logic             sr_di,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             busy
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SETTLE = 3'd2,
    SHIFT  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t           state, state_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic [BW-1:0]    bits, bits_d;
  logic             hi, hi_d;
  logic [WIDTH-1:0] shreg;
  logic             cnt_end;

  assign cnt_end = (cnt == CNT_LAST);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    bits_d  = bits;
    hi_d    = hi;
    case (state)
      IDLE: begin
        cnt_d  = '0;
        bits_d = '0;
        hi_d   = 1'b0;
        if (AUTO || start) state_d = LOAD;
      end
      LOAD: begin
        if (cnt_end) begin
          cnt_d   = '0;
          state_d = SETTLE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      SETTLE: begin
        if (cnt_end) begin
          cnt_d   = '0;
          bits_d  = '0;
          hi_d    = 1'b0;
          state_d = SHIFT;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      SHIFT: begin
        if (cnt_end) begin
          cnt_d = '0;
          if (hi) begin
            hi_d = 1'b0;
            if (bits == BIT_LAST) state_d = DONE;
            else                  bits_d  = bits + 1'b1;
          end else begin
            hi_d = 1'b1;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      DONE: begin
        cnt_d   = '0;
        bits_d  = '0;
        hi_d    = 1'b0;
        state_d = AUTO ? LOAD : IDLE;
      end
      default: begin
        cnt_d   = '0;
        bits_d  = '0;
        hi_d    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= '0;
      bits  <= '0;
      hi    <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      bits  <= bits_d;
      hi    <= hi_d;
    end
  end

  // Pins are registered decodes of the state, so they trail it by one cycle;
  // sr_di is captured on the edge where sr_clk is about to rise, i.e. the
  // last cycle of the low phase as seen on the pin.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sr_load_n <= 1'b1;
      sr_clk    <= 1'b0;
      busy      <= 1'b0;
      valid     <= 1'b0;
      shreg     <= '0;
      data      <= '0;
    end else begin
      sr_load_n <= (state != LOAD);
      sr_clk    <= (state == SHIFT) && hi;
      busy      <= (state != IDLE);
      valid     <= (state == DONE);
      if ((state == SHIFT) && hi && !sr_clk)
        shreg <= WIDTH'({shreg, sr_di});
      if (state == DONE)
        data <= INVERT ? ~shreg : shreg;
    end
  end

endmodule

// File: tb/tb_shift_in_scan.sv
// Bench for shift_in_scan: three instances (defaults, AUTO, narrow/fast/inverted)
// each reading its own behavioural 74HC165 chain.
module tb_shift_in_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] expect_word(input logic [31:0] pat, input int w, input bit inv);
    logic [31:0] mask;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    return (inv ? ~pat : pat) & mask;
  endfunction

  // ---------------- instance A: defaults ----------------
  logic        rstn_a = 1'b0, start_a = 1'b0;
  logic        load_n_a, srclk_a, di_a, valid_a, busy_a;
  logic [15:0] data_a, pre_a = '0, ch_a;

  shift_in_scan dut_a (
    .clk(clk), .rstn(rstn_a), .start(start_a), .sr_load_n(load_n_a), .sr_clk(srclk_a),
    .sr_di(di_a), .data(data_a), .valid(valid_a), .busy(busy_a)
  );

  always @(negedge load_n_a or posedge srclk_a)
    if (!load_n_a) ch_a <= pre_a;
    else           ch_a <= {ch_a[14:0], 1'b0};
  assign di_a = ch_a[15];

  int edges_a = 0, low_a = 0, valids_a = 0;
  always @(posedge srclk_a) edges_a <= edges_a + 1;
  always @(negedge clk) begin
    if (!load_n_a) low_a <= low_a + 1;
    if (valid_a)   valids_a <= valids_a + 1;
  end

  // ---------------- instance B: AUTO ----------------
  logic        rstn_b = 1'b0;
  logic        load_n_b, srclk_b, di_b, valid_b, busy_b;
  logic [15:0] data_b, pre_b = '0, ch_b;

  shift_in_scan #(.AUTO(1'b1)) dut_b (
    .clk(clk), .rstn(rstn_b), .start(1'b0), .sr_load_n(load_n_b), .sr_clk(srclk_b),
    .sr_di(di_b), .data(data_b), .valid(valid_b), .busy(busy_b)
  );

  always @(negedge load_n_b or posedge srclk_b)
    if (!load_n_b) ch_b <= pre_b;
    else           ch_b <= {ch_b[14:0], 1'b0};
  assign di_b = ch_b[15];

  // ---------------- instance C: WIDTH=8, CLK_DIV=1, INVERT ----------------
  logic       rstn_c = 1'b0, start_c = 1'b0;
  logic       load_n_c, srclk_c, di_c, valid_c, busy_c;
  logic [7:0] data_c, pre_c = '0, ch_c;

  shift_in_scan #(.WIDTH(8), .CLK_DIV(1), .INVERT(1'b1)) dut_c (
    .clk(clk), .rstn(rstn_c), .start(start_c), .sr_load_n(load_n_c), .sr_clk(srclk_c),
    .sr_di(di_c), .data(data_c), .valid(valid_c), .busy(busy_c)
  );

  always @(negedge load_n_c or posedge srclk_c)
    if (!load_n_c) ch_c <= pre_c;
    else           ch_c <= {ch_c[6:0], 1'b0};
  assign di_c = ch_c[7];

  int edges_c = 0;
  always @(posedge srclk_c) edges_c <= edges_c + 1;

  // One start pulse, then wait for valid; lat counts cycles from the start edge.
  task automatic run_a(input logic [15:0] pat, output int lat, output bit ok);
    pre_a = pat;
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    lat = 0;
    ok  = 1'b0;
    while (!ok && lat < 400) begin
      @(negedge clk);
      lat++;
      if (valid_a) ok = 1'b1;
    end
  endtask

  task automatic run_c(input logic [7:0] pat, output int lat, output bit ok, output int max_hi);
    int run;
    pre_c  = pat;
    run    = 0;
    max_hi = 0;
    @(negedge clk) start_c = 1'b1;
    @(negedge clk) start_c = 1'b0;
    lat = 0;
    ok  = 1'b0;
    while (!ok && lat < 100) begin
      @(negedge clk);
      lat++;
      run = srclk_c ? run + 1 : 0;
      if (run > max_hi) max_hi = run;
      if (valid_c) ok = 1'b1;
    end
  endtask

  task automatic wait_valid_a(output int lat, output bit ok);
    lat = 0;
    ok  = 1'b0;
    while (!ok && lat < 400) begin
      @(negedge clk);
      lat++;
      if (valid_a) ok = 1'b1;
    end
  endtask

  typedef struct {
    logic [7:0] pat;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int lat, e0, l0, v0, max_hi, unstable;
    bit ok;
    logic [15:0] rp;
    logic [7:0]  rc;

    tbl[0] = '{8'h3C, 8'hC3};
    tbl[1] = '{8'h00, 8'hFF};
    tbl[2] = '{8'hFF, 8'h00};
    tbl[3] = '{8'h81, 8'h7E};
    tbl[4] = '{8'hA5, 8'h5A};
    tbl[5] = '{8'h01, 8'hFE};

    pre_b = 16'h0001;
    repeat (3) @(negedge clk);
    check("rst_load_n", load_n_a, 1'b1);
    check("rst_sr_clk", srclk_a, 1'b0);
    check("rst_data", data_a, 16'h0000);
    check("rst_valid", valid_a, 1'b0);
    check("rst_busy", busy_a, 1'b0);
    rstn_a = 1'b1;
    rstn_b = 1'b1;
    rstn_c = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_no_start", busy_a, 1'b0);

    // AUTO: two scans 137 cycles apart, data stable in between
    wait_b: begin
      lat = 0;
      while (!valid_b && lat < 400) begin @(negedge clk); lat++; end
      check("auto_first_valid", valid_b, 1'b1);
      check("auto_data1", data_b, 16'h0001);
      pre_b    = 16'h8000;
      lat      = 0;
      unstable = 0;
      @(negedge clk);
      lat = 1;
      while (!valid_b && lat < 400) begin
        if (data_b !== 16'h0001) unstable++;
        @(negedge clk);
        lat++;
      end
      check("auto_period", lat, 137);
      check("auto_stable", unstable, 0);
      check("auto_data2", data_b, 16'h8000);
    end

    // single scan: latency, load width, edge count, busy tail
    e0 = edges_a;
    l0 = low_a;
    run_a(16'hA5C3, lat, ok);
    check("t1_done", ok, 1'b1);
    check("t1_latency", lat, 137);
    check("t1_data", data_a, 16'hA5C3);
    check("t1_edges", edges_a - e0, 16);
    check("t1_load_cycles", low_a - l0, 4);
    check("t1_busy_at_valid", busy_a, 1'b1);
    @(negedge clk);
    check("t1_valid_1cyc", valid_a, 1'b0);
    check("t1_busy_after", busy_a, 1'b0);

    // start during a scan is ignored
    v0 = valids_a;
    pre_a = 16'h5A3C;
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    repeat (49) @(negedge clk);
    pre_a = 16'h0F0F;
    start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    repeat (250) @(negedge clk);
    check("t2_one_valid", valids_a - v0, 1);
    check("t2_idle", busy_a, 1'b0);
    check("t2_data", data_a, 16'h5A3C);

    // async reset mid-scan
    v0 = valids_a;
    pre_a = 16'hBEEF;
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    repeat (59) @(negedge clk);
    rstn_a = 1'b0;
    #1;
    check("t4_load_n", load_n_a, 1'b1);
    check("t4_sr_clk", srclk_a, 1'b0);
    check("t4_busy", busy_a, 1'b0);
    check("t4_data", data_a, 16'h0000);
    check("t4_valid", valid_a, 1'b0);
    @(negedge clk) rstn_a = 1'b1;
    l0 = low_a;
    repeat (200) @(negedge clk);
    check("t4_quiet_busy", busy_a, 1'b0);
    check("t4_quiet_load", low_a - l0, 0);
    check("t4_no_valid", valids_a - v0, 0);
    run_a(16'h1234, lat, ok);
    check("t4_done", ok, 1'b1);
    check("t4_data_after", data_a, 16'h1234);
    @(negedge clk);

    // start held: back-to-back scans of all-zero then all-one
    pre_a = 16'h0000;
    @(negedge clk) start_a = 1'b1;
    wait_valid_a(lat, ok);
    check("t6_done0", ok, 1'b1);
    check("t6_data0", data_a, 16'h0000);
    pre_a = 16'hFFFF;
    wait_valid_a(lat, ok);
    check("t6_done1", ok, 1'b1);
    check("t6_gap", lat, 138);
    check("t6_data1", data_a, 16'hFFFF);
    pre_a = 16'h0000;
    wait_valid_a(lat, ok);
    start_a = 1'b0;
    check("t6_data2", data_a, 16'h0000);
    repeat (3) @(negedge clk);

    // randomized scans on A against the reference model
    for (int unsigned i = 0; i < 6; i++) begin
      rp = 16'($urandom);
      run_a(rp, lat, ok);
      check("rand_a_done", ok, 1'b1);
      check("rand_a_data", data_a, 64'(expect_word(32'(rp), 16, 1'b0)));
      @(negedge clk);
    end

    // narrow, fast, inverted instance
    e0 = edges_c;
    run_c(8'h3C, lat, ok, max_hi);
    check("t5_done", ok, 1'b1);
    check("t5_latency", lat, 19);
    check("t5_data", data_c, 8'hC3);
    check("t5_edges", edges_c - e0, 8);
    check("t5_hi_1cyc", max_hi, 1);
    @(negedge clk);
    for (int unsigned i = 0; i < 6; i++) begin
      run_c(tbl[i].pat, lat, ok, max_hi);
      check("tbl_c_done", ok, 1'b1);
      check("tbl_c_data", data_c, tbl[i].exp);
      @(negedge clk);
    end
    for (int unsigned i = 0; i < 6; i++) begin
      rc = 8'($urandom);
      run_c(rc, lat, ok, max_hi);
      check("rand_c_done", ok, 1'b1);
      check("rand_c_data", data_c, 64'(expect_word(32'(rc), 8, 1'b1)));
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
